// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, NB_DATA data bits LSB-first, one stop bit,
// each bit held for S_TICK baud ticks.
module uart_tx #(
    parameter int NB_DATA = 8,
    parameter int S_TICK  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_start,
    input  logic               s_tick,
    input  logic [NB_DATA-1:0] data_in,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done_tick
);

    localparam int TW = (S_TICK  > 1) ? $clog2(S_TICK)  : 1;
    localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(S_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic               tx_reg;
    logic               tick_end;

    assign tick_end = s_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_start) begin
                        shreg    <= data_in;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx_reg <= 1'b0;
                    if (s_tick) begin
                        if (tick_end) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    tx_reg <= shreg[0];
                    if (s_tick) begin
                        if (tick_end) begin
                            tick_cnt <= '0;
                            shreg    <= shreg >> 1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (s_tick) begin
                        if (tick_end) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by reset so an aborted frame never reports completion.
    assign tx_done_tick = reset && (state == STOP) && tick_end;
    assign tx_busy      = (state != IDLE);
    assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: tick-counting frame model, serial line decoder,
// a vector table for reset/acceptance corners and directed multi-frame sequences.
module tb_uart_tx;

    localparam int NB    = 8;
    localparam int S     = 16;
    localparam int TOTAL = (NB + 2) * S;

    logic          clk = 1'b0;
    logic          reset, tx_start, s_tick;
    logic [NB-1:0] data_in;
    logic          tx, tx_busy, tx_done_tick;

    uart_tx #(.NB_DATA(NB), .S_TICK(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .s_tick       (s_tick),
        .data_in      (data_in),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is TOTAL ticks long; bit index = ticks / S.
    bit            m_active = 1'b0;
    int            m_nt     = 0;
    logic          m_tx     = 1'b1;
    logic [NB-1:0] m_bits   = '0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] rx_q[$];

    function automatic logic frame_level(input logic [NB-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= NB) return b[idx-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            if (m_active && exp_q.size() > 0) void'(exp_q.pop_back());
            m_active = 1'b0;
            m_nt     = 0;
            m_tx     = 1'b1;
        end else if (m_active) begin
            m_tx = frame_level(m_bits, m_nt / S);
            if (s_tick) begin
                if (m_nt == TOTAL - 1) m_active = 1'b0;
                else m_nt++;
            end
        end else begin
            m_tx = 1'b1;
            if (tx_start) begin
                m_active = 1'b1;
                m_nt     = 0;
                m_bits   = data_in;
                exp_q.push_back(data_in);
            end
        end
    end

    // Line decoder: mid-bit sampling counted in baud ticks.
    int            d_state = 0, d_cnt = 0, d_n = 0;
    logic [NB-1:0] d_byte  = '0;

    task automatic decode();
        if (!reset) begin
            d_state = 0;
        end else begin
            case (d_state)
                0: if (tx == 1'b0) begin d_state = 1; d_cnt = 0; end
                1: if (s_tick) begin
                    d_cnt++;
                    if (d_cnt == S / 2) begin
                        if (tx == 1'b0) begin d_state = 2; d_cnt = 0; d_n = 0; end
                        else d_state = 0;
                    end
                end
                2: if (s_tick) begin
                    d_cnt++;
                    if (d_cnt == S) begin
                        d_byte[d_n] = tx;
                        d_n++;
                        d_cnt = 0;
                        if (d_n == NB) d_state = 3;
                    end
                end
                default: if (s_tick) begin
                    d_cnt++;
                    if (d_cnt == S) begin
                        check("stop_bit", tx, 1);
                        rx_q.push_back(d_byte);
                        d_state = 0;
                    end
                end
            endcase
        end
    endtask

    int   mode = 0, tdiv = 0, done_cnt = 0;
    logic last_done;
    bit   rec_en = 1'b0;
    logic rec_lvl;
    int   rec_len;
    int   runs[$];

    // One clock: drive tick, check done before the edge, check line after it.
    task automatic cyc();
        if (mode == 1) begin
            s_tick = (tdiv == 0);
            tdiv   = (tdiv + 1) % 4;
        end else if (mode == 2) begin
            s_tick = ($urandom_range(0, 2) == 0);
        end
        #1;
        last_done = tx_done_tick;
        check("done", tx_done_tick, reset && m_active && s_tick && (m_nt == TOTAL - 1));
        if (tx_done_tick === 1'b1) done_cnt++;
        @(negedge clk);
        check("line", {tx, tx_busy}, {m_tx, m_active});
        decode();
        if (rec_en) begin
            if (tx == rec_lvl) rec_len++;
            else begin
                runs.push_back(rec_len);
                rec_lvl = tx;
                rec_len = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (tx_busy && k < limit) begin
            cyc();
            k++;
        end
        check("idle_timeout", tx_busy, 0);
    endtask

    task automatic wait_bit(input int idx, input int limit);
        int k = 0;
        while (!(m_active && (m_nt / S == idx)) && k < limit) begin
            cyc();
            k++;
        end
        check("bit_timeout", m_active && (m_nt / S == idx), 1);
    endtask

    task automatic send(input logic [NB-1:0] b);
        wait_idle(5000);
        tx_start = 1'b1;
        data_in  = b;
        cyc();
        tx_start = 1'b0;
    endtask

    task automatic expect_rx(input int n, input logic [NB-1:0] b0, input logic [NB-1:0] b1,
                             input logic [NB-1:0] b2);
        logic [NB-1:0] e[3];
        e = '{b0, b1, b2};
        check("rx_count", rx_q.size(), n);
        check("acc_count", exp_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check("rx_byte", rx_q[i], e[i]);
            if (i < exp_q.size()) check("acc_byte", exp_q[i], e[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic          rst, st, tk;
        logic [NB-1:0] d;
        logic          etx, ebusy, edone;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0, nacc;
        int exp_runs[6];

        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        reset = 1'b0; tx_start = 1'b0; s_tick = 1'b0; data_in = '0; mode = 0;

        for (int i = 0; i < 3; i++) begin
            tx_start = 1'($urandom_range(0, 1));
            s_tick   = 1'($urandom_range(0, 1));
            data_in  = NB'($urandom);
            cyc();
            check("rst_tx", tx, 1);
            check("rst_busy", tx_busy, 0);
            check("rst_done", last_done, 0);
        end

        for (int i = 0; i < 6; i++) begin
            reset = tbl[i].rst; tx_start = tbl[i].st; s_tick = tbl[i].tk; data_in = tbl[i].d;
            cyc();
            check("tbl_tx", tx, tbl[i].etx);
            check("tbl_busy", tx_busy, tbl[i].ebusy);
            check("tbl_done", last_done, tbl[i].edone);
        end
        tx_start = 1'b0;
        expect_rx(0, 8'h00, 8'h00, 8'h00);

        // Single frame 0xA5, tick every 4 clocks: data bits last exactly 64 clocks.
        mode = 1; tdiv = 0; d0 = done_cnt;
        runs.delete(); rec_en = 1'b1; rec_lvl = 1'b1; rec_len = 0;
        send(8'hA5);
        wait_idle(5000);
        idle(8);
        rec_en = 1'b0;
        exp_runs = '{64, 64, 64, 128, 64, 64};
        check("run_count", runs.size() >= 8, 1);
        if (runs.size() >= 8) begin
            check("start_len", (runs[1] >= 61) && (runs[1] <= 64), 1);
            for (int i = 0; i < 6; i++) check("run_len", runs[i+2], exp_runs[i]);
        end
        check("a5_done", done_cnt - d0, 1);
        expect_rx(1, 8'hA5, 8'h00, 8'h00);

        // Back-to-back frames.
        d0 = done_cnt;
        send(8'h3C); send(8'hFF); send(8'h00);
        wait_idle(5000);
        idle(4);
        check("b2b_done", done_cnt - d0, 3);
        expect_rx(3, 8'h3C, 8'hFF, 8'h00);

        // Busy rejection.
        mode = 2; d0 = done_cnt;
        send(8'h55);
        wait_bit(3, 3000);
        tx_start = 1'b1; data_in = 8'h0F;
        cyc();
        tx_start = 1'b0;
        wait_idle(5000);
        idle(20);
        check("rej_done", done_cnt - d0, 1);
        check("rej_line", tx, 1);
        expect_rx(1, 8'h55, 8'h00, 8'h00);

        // Reset during the third data bit.
        mode = 1; d0 = done_cnt;
        send(8'h81);
        wait_bit(3, 3000);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("abort_tx", tx, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_done", last_done, 0);
        idle(4);
        check("abort_done_cnt", done_cnt - d0, 0);
        expect_rx(0, 8'h00, 8'h00, 8'h00);
        send(8'h81);
        wait_idle(5000);
        idle(4);
        check("resend_done", done_cnt - d0, 1);
        expect_rx(1, 8'h81, 8'h00, 8'h00);

        // data_in churns every clock after acceptance.
        mode = 2; d0 = done_cnt;
        send(8'hC3);
        for (int k = 0; k < 5000 && tx_busy; k++) begin
            data_in = NB'($urandom);
            cyc();
        end
        check("stab_busy", tx_busy, 0);
        idle(4);
        check("stab_done", done_cnt - d0, 1);
        expect_rx(1, 8'hC3, 8'h00, 8'h00);

        // Random start requests, data and ticks.
        d0 = done_cnt;
        for (int i = 0; i < 12000; i++) begin
            tx_start = ($urandom_range(0, 15) == 0);
            data_in  = NB'($urandom);
            cyc();
        end
        tx_start = 1'b0;
        wait_idle(5000);
        idle(20);
        nacc = exp_q.size();
        check("rand_frames", nacc > 5, 1);
        check("rand_done", done_cnt - d0, nacc);
        check("rand_count", rx_q.size(), nacc);
        for (int i = 0; i < nacc && i < rx_q.size(); i++) check("rand_byte", rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
